pwm_fade_ctrl: RTL and testbench



---
 rtl/pwm_fade_ctrl.sv | 82 ++++++++
 tb/tb_pwm_fade_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_fade_ctrl.sv
// pwm_fade_ctrl: PWM period counter and comparator with period-aligned duty ramping driven by valid/ready commands
module pwm_fade_ctrl #(
  parameter int PERIOD = 100,
  parameter int DW     = $clog2(PERIOD + 1),
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DW-1:0]     cmd_target,
  input  logic [DW-1:0]     cmd_step,
  input  logic [HOLD_W-1:0] cmd_hold,
  output logic              pwm,
  output logic [DW-1:0]     duty,
  output logic              busy,
  output logic              done
);
  localparam int CW = $clog2(PERIOD);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RAMP = 1'b1;

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [0:0]        state_q, state_d;
  logic [DW-1:0]     duty_q, duty_d;
  logic [DW-1:0]     tgt_q, tgt_d;
  logic [DW-1:0]     step_q, step_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [HOLD_W-1:0] hcnt_q, hcnt_d;
  logic              done_q, done_d;
  logic              boundary, accept, ramp_tick, step_now, up, last;
  logic [DW-1:0]     diff;

  assign boundary  = cnt_q == CW'(PERIOD - 1);
  assign accept    = state_q == IDLE && cmd_valid;
  assign ramp_tick = state_q == RAMP && boundary;
  assign step_now  = ramp_tick && hcnt_q == hold_q - HOLD_W'(1);
  assign up        = tgt_q > duty_q;
  assign diff      = up ? tgt_q - duty_q : duty_q - tgt_q;
  assign last      = step_q == '0 || diff <= step_q;

  assign cmd_ready = state_q == IDLE;
  assign busy      = state_q == RAMP;
  assign done      = done_q;
  assign duty      = duty_q;
  assign pwm       = DW'(cnt_q) < duty_q;

  // Next state: latch commands in IDLE, count boundaries and apply steps in RAMP
  always_comb begin
    cnt_d   = boundary ? '0 : cnt_q + CW'(1);
    tgt_d   = accept ? (cmd_target > DW'(PERIOD) ? DW'(PERIOD) : cmd_target) : tgt_q;
    step_d  = accept ? cmd_step : step_q;
    hold_d  = accept ? (cmd_hold == '0 ? HOLD_W'(1) : cmd_hold) : hold_q;
    hcnt_d  = accept ? '0 : step_now ? '0 : ramp_tick ? hcnt_q + HOLD_W'(1) : hcnt_q;
    duty_d  = step_now ? (last ? tgt_q : up ? duty_q + step_q : duty_q - step_q) : duty_q;
    state_d = accept ? RAMP : (step_now && last) ? IDLE : state_q;
    done_d  = step_now && last;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= '0;
      state_q <= IDLE;
      duty_q  <= '0;
      tgt_q   <= '0;
      step_q  <= '0;
      hold_q  <= '0;
      hcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
      duty_q  <= duty_d;
      tgt_q   <= tgt_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      hcnt_q  <= hcnt_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// tb_pwm_fade_ctrl: randomized and directed checks of pwm_fade_ctrl against a period-level reference model
module tb_pwm_fade_ctrl;
  localparam int PERIOD = 100;
  localparam int DW = $clog2(PERIOD + 1);
  localparam int HOLD_W = 8;
  localparam logic [DW+3:0] RST_V = {1'b0, DW'(0), 1'b0, 1'b0, 1'b1};

  logic clk = 1'b0, rstn = 1'b0, cmd_valid = 1'b0;
  logic [DW-1:0] cmd_target = '0, cmd_step = '0;
  logic [HOLD_W-1:0] cmd_hold = '0;
  logic cmd_ready, pwm, busy, done;
  logic [DW-1:0] duty;

  int checks = 0, failures = 0;

  pwm_fade_ctrl #(.PERIOD(PERIOD), .DW(DW), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_step(cmd_step), .cmd_hold(cmd_hold),
    .pwm(pwm), .duty(duty), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference model: cycle position in the period, boundaries seen since accept, integer duty arithmetic
  typedef struct packed {
    int cnt; int duty; int busy; int target; int step; int hold; int nb; int done;
  } mst_t;
  mst_t m;

  function automatic mst_t model_next(mst_t s, logic v, int t, int st, int h);
    mst_t n;
    int d;
    n = s;
    n.done = 0;
    n.cnt = (s.cnt + 1) % PERIOD;
    if (s.busy == 0) begin
      if (v) begin
        n.busy = 1; n.target = (t > PERIOD) ? PERIOD : t; n.step = st;
        n.hold = (h == 0) ? 1 : h; n.nb = 0;
      end
    end else if (s.cnt == PERIOD - 1) begin
      n.nb = s.nb + 1;
      if (n.nb % s.hold == 0) begin
        d = (s.target > s.duty) ? s.target - s.duty : s.duty - s.target;
        if (s.step == 0 || d <= s.step) begin
          n.duty = s.target; n.busy = 0; n.done = 1;
        end else n.duty = (s.target > s.duty) ? s.duty + s.step : s.duty - s.step;
      end
    end
    return n;
  endfunction

  always @(posedge clk or negedge rstn)
    if (!rstn) m <= '0;
    else m <= model_next(m, cmd_valid, int'(cmd_target), int'(cmd_step), int'(cmd_hold));

  logic [DW+3:0] obs_v, exp_v;
  assign obs_v = {pwm, duty, busy, done, cmd_ready};
  assign exp_v = {m.cnt < m.duty, DW'(m.duty), m.busy != 0, m.done != 0, m.busy == 0};

  int r_vals[$], r_times[$];
  int r_dones, r_bad, r_hi, r_done_duty;
  logic [DW+3:0] r_obs, r_exp;

  task automatic send(input int t, input int st, input int h);
    cmd_target = DW'(t); cmd_step = DW'(st); cmd_hold = HOLD_W'(h); cmd_valid = 1'b1;
  endtask

  task automatic run(input int n);
    int prev;
    prev = int'(duty);
    r_vals.delete(); r_times.delete();
    r_dones = 0; r_bad = 0; r_hi = 0; r_done_duty = -1;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (obs_v !== exp_v) begin
        if (r_bad == 0) begin r_obs = obs_v; r_exp = exp_v; end
        r_bad++;
      end
      if (int'(duty) != prev) begin r_vals.push_back(int'(duty)); r_times.push_back(i); prev = int'(duty); end
      if (done) begin r_dones++; r_done_duty = int'(duty); end
      if (i >= n - PERIOD) r_hi += int'(pwm);
    end
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (obs_v !== RST_V) begin failures++; $display("FAIL reset_hold obs=%h exp=%h", obs_v, RST_V); end
    end
    rstn = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      checks++;
      if (obs_v !== RST_V || obs_v !== exp_v) begin
        failures++; $display("FAIL idle_after_reset cyc=%0d obs=%h exp=%h", i, obs_v, RST_V);
      end
    end
  endtask

  task automatic test_jump();
    send(25, 0, 1);
    run(250);
    checks++; if (r_bad != 0) begin failures++; $display("FAIL jump_model bad=%0d obs=%h exp=%h", r_bad, r_obs, r_exp); end
    checks++; if (r_dones != 1 || r_done_duty != 25) begin failures++; $display("FAIL jump_done dones=%0d duty=%0d exp 1/25", r_dones, r_done_duty); end
    checks++; if (r_vals.size() != 1 || r_vals[0] != 25 || r_times[0] > PERIOD) begin failures++; $display("FAIL jump_update n=%0d duty=%0d t=%0d", r_vals.size(), r_vals[0], r_times[0]); end
    checks++; if (r_hi != 25) begin failures++; $display("FAIL jump_pwm_high got=%0d exp=25", r_hi); end
  endtask

  task automatic test_clamp();
    send(120, 0, 1);
    run(250);
    checks++; if (r_bad != 0) begin failures++; $display("FAIL clamp_model bad=%0d obs=%h exp=%h", r_bad, r_obs, r_exp); end
    checks++; if (duty !== DW'(100) || r_hi != PERIOD) begin failures++; $display("FAIL clamp_full duty=%0d hi=%0d exp 100/100", duty, r_hi); end
    send(0, 0, 1);
    run(250);
    checks++; if (r_bad != 0) begin failures++; $display("FAIL zero_model bad=%0d obs=%h exp=%h", r_bad, r_obs, r_exp); end
    checks++; if (duty !== DW'(0) || r_hi != 0 || r_done_duty != 0) begin failures++; $display("FAIL zero_duty duty=%0d hi=%0d exp 0/0", duty, r_hi); end
  endtask

  task automatic test_ramp_up();
    send(40, 10, 2);
    run(1000);
    checks++; if (r_bad != 0) begin failures++; $display("FAIL up_model bad=%0d obs=%h exp=%h", r_bad, r_obs, r_exp); end
    checks++; if (r_vals.size() != 4) begin failures++; $display("FAIL up_steps got=%0d exp=4", r_vals.size()); end
    for (int k = 0; k < r_vals.size(); k++) begin
      checks++; if (r_vals[k] != 10 * (k + 1)) begin failures++; $display("FAIL up_val%0d got=%0d exp=%0d", k, r_vals[k], 10 * (k + 1)); end
    end
    for (int k = 1; k < r_times.size(); k++) begin
      checks++; if (r_times[k] - r_times[k-1] != 2 * PERIOD) begin failures++; $display("FAIL up_gap%0d got=%0d exp=%0d", k, r_times[k] - r_times[k-1], 2 * PERIOD); end
    end
    checks++; if (r_dones != 1 || r_done_duty != 40 || busy !== 1'b0) begin failures++; $display("FAIL up_done dones=%0d duty=%0d busy=%b", r_dones, r_done_duty, busy); end
  endtask

  task automatic test_ramp_down();
    send(5, 15, 0);
    run(500);
    checks++; if (r_bad != 0) begin failures++; $display("FAIL down_model bad=%0d obs=%h exp=%h", r_bad, r_obs, r_exp); end
    checks++; if (r_vals.size() != 3 || r_vals[0] != 25 || r_vals[1] != 10 || r_vals[2] != 5) begin
      failures++; $display("FAIL down_vals n=%0d got=%0d,%0d,%0d exp 25,10,5", r_vals.size(), r_vals[0], r_vals[1], r_vals[2]);
    end
    checks++; if (r_times[1] - r_times[0] != PERIOD || r_times[2] - r_times[1] != PERIOD) begin failures++; $display("FAIL down_gap got=%0d,%0d exp=%0d", r_times[1] - r_times[0], r_times[2] - r_times[1], PERIOD); end
    checks++; if (r_dones != 1 || r_done_duty != 5) begin failures++; $display("FAIL down_done dones=%0d duty=%0d exp 1/5", r_dones, r_done_duty); end
  endtask

  task automatic test_boundary_accept();
    int w;
    w = 0;
    while (m.cnt != PERIOD - 1 && w < 2 * PERIOD) begin @(negedge clk); w++; end
    checks++; if (m.cnt != PERIOD - 1) begin failures++; $display("FAIL bnd_align timeout cnt=%0d", m.cnt); end
    send(50, 0, 1);
    run(150);
    checks++; if (r_bad != 0) begin failures++; $display("FAIL bnd_model bad=%0d obs=%h exp=%h", r_bad, r_obs, r_exp); end
    checks++; if (r_times.size() != 1 || r_times[0] != PERIOD || r_vals[0] != 50) begin
      failures++; $display("FAIL bnd_latency n=%0d t=%0d duty=%0d exp t=%0d duty=50", r_times.size(), r_times[0], r_vals[0], PERIOD);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    bit got;
    bad = 0; got = 0;
    send(20, 10, 1);
    @(negedge clk);
    cmd_target = DW'(80); cmd_step = '0; cmd_hold = HOLD_W'(1);
    for (int i = 0; i < 600 && !got; i++) begin
      @(negedge clk);
      if (obs_v !== exp_v) bad++;
      if (done) begin
        checks++; if (cmd_ready !== 1'b1 || duty !== DW'(20)) begin failures++; $display("FAIL b2b_done ready=%b duty=%0d exp 1/20", cmd_ready, duty); end
        @(negedge clk);
        checks++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept busy=%b ready=%b exp 1/0", busy, cmd_ready); end
        got = 1;
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    checks++; if (!got) begin failures++; $display("FAIL b2b_timeout done never seen"); end
    checks++; if (bad != 0) begin failures++; $display("FAIL b2b_model bad=%0d", bad); end
    run(250);
    checks++; if (r_bad != 0 || r_vals.size() != 1 || r_done_duty != 80) begin
      failures++; $display("FAIL b2b_second bad=%0d n=%0d duty=%0d exp 0/1/80", r_bad, r_vals.size(), r_done_duty);
    end
  endtask

  task automatic test_reset_mid_ramp();
    send(0, 5, 3);
    run(400);
    checks++; if (busy !== 1'b1 || duty === DW'(0)) begin failures++; $display("FAIL rst_pre busy=%b duty=%0d exp busy=1 duty!=0", busy, duty); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (obs_v !== RST_V) begin failures++; $display("FAIL rst_async obs=%h exp=%h", obs_v, RST_V); end
    @(negedge clk);
    rstn = 1'b1;
    run(300);
    checks++; if (r_bad != 0 || r_vals.size() != 0 || duty !== DW'(0)) begin
      failures++; $display("FAIL rst_after bad=%0d changes=%0d duty=%0d", r_bad, r_vals.size(), duty);
    end
  endtask

  task automatic test_random();
    int t, st, h, bad;
    bit got;
    for (int n = 0; n < 8; n++) begin
      t = $urandom_range(0, 127);
      st = $urandom_range(0, 30);
      if (st != 0 && st < 8) st += 8;
      h = $urandom_range(0, 2);
      repeat ($urandom_range(0, 7)) @(negedge clk);
      send(t, st, h);
      bad = 0; got = 0;
      for (int i = 0; i < 4000 && !got; i++) begin
        @(negedge clk);
        cmd_valid = 1'b0;
        if (obs_v !== exp_v) bad++;
        if (done) got = 1;
      end
      checks++; if (!got) begin failures++; $display("FAIL rand%0d_timeout t=%0d st=%0d h=%0d", n, t, st, h); end
      checks++; if (bad != 0 || int'(duty) != ((t > PERIOD) ? PERIOD : t)) begin
        failures++; $display("FAIL rand%0d bad=%0d duty=%0d exp=%0d", n, bad, duty, (t > PERIOD) ? PERIOD : t);
      end
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_clamp();
    test_ramp_up();
    test_ramp_down();
    test_boundary_accept();
    test_back_to_back();
    test_reset_mid_ramp();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
